// File: rtl/adc128s_fc_model.sv
// Behavioural-but-synthesizable model of an ADC128S-style SPI ADC front end.
// Optional ADC128S_TRACK_HOLD_EN samples the addressed input at command end instead of at response start.
module adc128s_fc_model #(
  parameter int CH_LFT   = 0,
  parameter int CH_RGHT  = 4,
  parameter int CH_STEER = 5,
  parameter int CH_BATT  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic        ss_ff1_q, ss_ff2_q, ss_ff3_q;
  logic        sclk_ff1_q, sclk_ff2_q, sclk_ff3_q;
  logic        mosi_ff1_q, mosi_ff2_q;

  logic [1:0]  init_q, init_d;
  logic        armed_q, armed_d;
  logic        frame_q, frame_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic [2:0]  chnl_q, chnl_d;
  logic        miso_q, miso_d;
`ifdef ADC128S_TRACK_HOLD_EN
  logic [11:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
`endif

  logic        ss_low, ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [11:0] load_val;
  logic        unused_rx;

  function automatic logic [11:0] chan_value(
    input logic [2:0]  ch,
    input logic [11:0] lft,
    input logic [11:0] rght,
    input logic [11:0] steer,
    input logic [11:0] bat
  );
    if (ch == 3'(CH_LFT))        return lft;
    else if (ch == 3'(CH_RGHT))  return rght;
    else if (ch == 3'(CH_STEER)) return steer;
    else if (ch == 3'(CH_BATT))  return bat;
    else                         return 12'h000;
  endfunction

  // Synchronizers: SS_n/SCLK idle high out of reset so no false edges appear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_ff1_q   <= 1'b1;
      ss_ff2_q   <= 1'b1;
      ss_ff3_q   <= 1'b1;
      sclk_ff1_q <= 1'b1;
      sclk_ff2_q <= 1'b1;
      sclk_ff3_q <= 1'b1;
      mosi_ff1_q <= 1'b0;
      mosi_ff2_q <= 1'b0;
    end else begin
      ss_ff1_q   <= SS_n;
      ss_ff2_q   <= ss_ff1_q;
      ss_ff3_q   <= ss_ff2_q;
      sclk_ff1_q <= SCLK;
      sclk_ff2_q <= sclk_ff1_q;
      sclk_ff3_q <= sclk_ff2_q;
      mosi_ff1_q <= MOSI;
      mosi_ff2_q <= mosi_ff1_q;
    end
  end

  assign ss_low    = ~ss_ff2_q;
  assign ss_fall   = armed_q & ss_ff3_q & ~ss_ff2_q;
  assign ss_rise   = ~ss_ff3_q & ss_ff2_q;
  assign sclk_rise = ~sclk_ff3_q & sclk_ff2_q;
  assign sclk_fall = sclk_ff3_q & ~sclk_ff2_q;
  assign unused_rx = rx_q[15];

`ifdef ADC128S_TRACK_HOLD_EN
  assign load_val = hold_vld_q ? hold_q
                  : chan_value(chnl_q, ld_cell_lft, ld_cell_rght, steerPot, batt);
`else
  assign load_val = chan_value(chnl_q, ld_cell_lft, ld_cell_rght, steerPot, batt);
`endif

  always_comb begin
    init_d    = init_q;
    armed_d   = armed_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    chnl_d    = chnl_q;
`ifdef ADC128S_TRACK_HOLD_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif

    // Arm only after the synchronizer holds real samples and SS_n has been seen high,
    // so a select already low when reset releases never opens a frame.
    if (init_q != 2'd3) init_d = init_q + 2'd1;
    if ((init_q == 2'd3) && ss_ff2_q) armed_d = 1'b1;

    if (ss_fall) begin
      frame_d   = 1'b1;
      bit_cnt_d = 5'd0;
      rx_d      = 16'h0000;
      tx_d      = {4'h0, load_val};
    end else if (frame_q && ss_low) begin
      if (sclk_rise) begin
        rx_d = {rx_q[14:0], mosi_ff2_q};
        if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
      end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
        tx_d = {tx_q[14:0], 1'b0};
      end
    end

    if (ss_rise) begin
      frame_d = 1'b0;
      if (frame_q && (bit_cnt_q == 5'd16)) begin
        chnl_d = rx_q[13:11];
`ifdef ADC128S_TRACK_HOLD_EN
        hold_d     = chan_value(rx_q[13:11], ld_cell_lft, ld_cell_rght, steerPot, batt);
        hold_vld_d = 1'b1;
`endif
      end
    end

    miso_d = ss_low ? tx_q[15] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q    <= 2'd0;
      armed_q   <= 1'b0;
      frame_q   <= 1'b0;
      bit_cnt_q <= 5'd0;
      rx_q      <= 16'h0000;
      tx_q      <= 16'h0000;
      chnl_q    <= 3'd0;
      miso_q    <= 1'b1;
`ifdef ADC128S_TRACK_HOLD_EN
      hold_q     <= 12'h000;
      hold_vld_q <= 1'b0;
`endif
    end else begin
      init_q    <= init_d;
      armed_q   <= armed_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      chnl_q    <= chnl_d;
      miso_q    <= miso_d;
`ifdef ADC128S_TRACK_HOLD_EN
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
`endif
    end
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_adc128s_fc_model.sv
// Bench for adc128s_fc_model: SPI master driving frames, checked against a frame-level channel model.
module tb_adc128s_fc_model;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] lft, rght, steer, batt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: channel selected by the last complete 16-bit command.
  int          m_chnl;
  logic [11:0] m_hold;
  bit          m_hold_vld;

  adc128s_fc_model dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (lft),
    .ld_cell_rght (rght),
    .steerPot     (steer),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ref_val(input int ch);
    case (ch)
      0:       return lft;
      4:       return rght;
      5:       return steer;
      6:       return batt;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [15:0] model_expect();
`ifdef ADC128S_TRACK_HOLD_EN
    if (m_hold_vld) return {4'h0, m_hold};
`endif
    return {4'h0, ref_val(m_chnl)};
  endfunction

  function automatic void model_end(input logic [15:0] w, input int nbits);
    if (nbits == 16) begin
      m_chnl     = int'(w[13:11]);
      m_hold     = ref_val(m_chnl);
      m_hold_vld = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_chnl     = 0;
    m_hold     = 12'h000;
    m_hold_vld = 1'b0;
  endfunction

  task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [15:0] r);
    logic [31:0] ext;
    ext = {w, 16'h0000};
    r   = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      MOSI = ext[31-i];
      repeat (HALF) @(negedge clk);
      if (i < 16) r[15-i] = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] r);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(w, nbits, r);
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic apply_reset(input logic ss_level);
    @(negedge clk);
    rst  = 1'b1;
    SS_n = ss_level;
    SCLK = 1'b0;
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    @(negedge clk);
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    #1;
    n_checks++;
    if (MISO !== 1'b1) begin
      n_fail++; $display("FAIL reset_miso_in_rst got=%b exp=1", MISO);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (HALF) @(negedge clk);
    n_checks++;
    if (MISO !== 1'b1) begin
      n_fail++; $display("FAIL reset_miso_idle got=%b exp=1", MISO);
    end
    lft = 12'h6C6;
    exp = model_expect();
    spi_frame(16'h0000, 16, got); model_end(16'h0000, 16);
    n_checks++;
    if (got !== 16'h06C6 || got !== exp) begin
      n_fail++; $display("FAIL reset_first_frame got=%h exp=%h", got, 16'h06C6);
    end
  endtask

  task automatic test_channel_select();
    logic [15:0] got, exp;
    rght  = 12'hE27;
    steer = 12'h5A3;
    spi_frame(16'h2000, 16, got); model_end(16'h2000, 16);
    exp = model_expect();
    spi_frame(16'h2800, 16, got); model_end(16'h2800, 16);
    n_checks++;
    if (got !== 16'h0E27 || got !== exp) begin
      n_fail++; $display("FAIL chsel_ch4 got=%h exp=%h", got, 16'h0E27);
    end
    exp = model_expect();
    spi_frame(16'h3000, 16, got); model_end(16'h3000, 16);
    n_checks++;
    if (got !== 16'h05A3 || got !== exp) begin
      n_fail++; $display("FAIL chsel_ch5 got=%h exp=%h", got, 16'h05A3);
    end
  endtask

  task automatic test_batt_unmapped();
    logic [15:0] got, exp;
    batt = 12'hDA8;
    spi_frame(16'h3000, 16, got); model_end(16'h3000, 16);
    exp = model_expect();
    spi_frame(16'h3800, 16, got); model_end(16'h3800, 16);
    n_checks++;
    if (got !== 16'h0DA8 || got !== exp) begin
      n_fail++; $display("FAIL batt_ch6 got=%h exp=%h", got, 16'h0DA8);
    end
    exp = model_expect();
    spi_frame(16'h0000, 16, got); model_end(16'h0000, 16);
    n_checks++;
    if (got !== 16'h0000 || got !== exp) begin
      n_fail++; $display("FAIL unmapped_ch7 got=%h exp=%h", got, 16'h0000);
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] got, exp;
    rght = 12'h3C1;
    spi_frame(16'h2000, 16, got); model_end(16'h2000, 16);
    spi_frame(16'h2800, 8, got);  model_end(16'h2800, 8);
    exp = model_expect();
    spi_frame(16'h0000, 16, got); model_end(16'h0000, 16);
    n_checks++;
    if (got !== 16'h03C1 || got !== exp) begin
      n_fail++; $display("FAIL short_frame_keeps_chnl got=%h exp=%h", got, 16'h03C1);
    end
  endtask

  task automatic test_sample_point();
    logic [15:0] got, req;
    batt = 12'h800;
    spi_frame(16'h3000, 16, got); model_end(16'h3000, 16);
    batt = 12'h900;
`ifdef ADC128S_TRACK_HOLD_EN
    req = 16'h0800;
`else
    req = 16'h0900;
`endif
    spi_frame(16'h0000, 16, got); model_end(16'h0000, 16);
    n_checks++;
    if (got !== req) begin
      n_fail++; $display("FAIL sample_point got=%h exp=%h", got, req);
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [15:0] got, exp;
    spi_frame(16'h3800, 16, got); model_end(16'h3800, 16);
    SS_n = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(16'h3000, 7, got);
    rst = 1'b1;
    #1;
    n_checks++;
    if (MISO !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_frame_miso got=%b exp=1", MISO);
    end
    @(negedge clk);
    SS_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (HALF) @(negedge clk);
    lft = 12'h4B7;
    exp = model_expect();
    spi_frame(16'h0000, 16, got); model_end(16'h0000, 16);
    n_checks++;
    if (got !== 16'h04B7 || got !== exp) begin
      n_fail++; $display("FAIL rst_mid_frame_next got=%h exp=%h", got, 16'h04B7);
    end
  endtask

  task automatic test_ss_low_at_reset();
    logic [15:0] got, exp;
    apply_reset(1'b0);
    batt = 12'h123;
    spi_bits(16'h3000, 16, got);
    repeat (HALF) @(negedge clk);
    SS_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    lft = 12'hA5C;
    exp = model_expect();
    spi_frame(16'h0000, 16, got); model_end(16'h0000, 16);
    n_checks++;
    if (got !== 16'h0A5C || got !== exp) begin
      n_fail++; $display("FAIL ss_low_at_reset got=%h exp=%h", got, 16'h0A5C);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp, w;
    int          nb, sel;
    for (int k = 0; k < 24; k++) begin
      lft   = 12'($urandom_range(0, 4095));
      rght  = 12'($urandom_range(0, 4095));
      steer = 12'($urandom_range(0, 4095));
      batt  = 12'($urandom_range(0, 4095));
      w     = 16'($urandom);
      sel   = $urandom_range(0, 5);
      nb    = (sel == 0) ? 8 : (sel == 1) ? 20 : 16;
      exp   = model_expect();
      spi_frame(w, nb, got);
      model_end(w, nb);
      n_checks++;
      if (nb >= 16) begin
        if (got !== exp) begin
          n_fail++; $display("FAIL random_frame%0d got=%h exp=%h", k, got, exp);
        end
      end else if (got[15:8] !== exp[15:8]) begin
        n_fail++; $display("FAIL random_short%0d got=%h exp=%h", k, got[15:8], exp[15:8]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    lft = 12'h000; rght = 12'h000; steer = 12'h000; batt = 12'h000;
    model_reset();
    test_reset();
    test_channel_select();
    test_batt_unmapped();
    test_short_frame();
    test_sample_point();
    test_rst_mid_frame();
    test_ss_low_at_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
